// File: rtl/reg_mem_pkg.sv
// Shared types and limits for the register-block memory responder.
//   state_e             : responder FSM states
//   SRAM_RD_LATENCY_MAX : largest supported SRAM read latency
package reg_mem_pkg;

  localparam int unsigned SRAM_RD_LATENCY_MAX = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    RDWAIT  = 3'd2,
    ACK     = 3'd3,
    RECOVER = 3'd4
  } state_e;

endpackage

// File: rtl/reg_mem_responder_if.sv
// Memory request/ack bus between the native-if-to-mem bridge and the responder.
//   master : bridge side  (drives req/addr/cmd/wr_data, receives ack/err/rd_data)
//   slave  : responder side
interface reg_mem_responder_if #(
  parameter int unsigned MEM_DATA_WIDTH = 64,
  parameter int unsigned MEM_ADDR_WIDTH = 5
);

  logic                      mem_req_vld;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_wr_en;
  logic                      mem_rd_en;
  logic [MEM_DATA_WIDTH-1:0] mem_wr_data;
  logic                      mem_ack_vld;
  logic                      mem_err;
  logic [MEM_DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output mem_req_vld, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data,
    input  mem_ack_vld, mem_err, mem_rd_data
  );

  modport slave (
    input  mem_req_vld, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data,
    output mem_ack_vld, mem_err, mem_rd_data
  );

endinterface

// File: rtl/reg_mem_responder.sv
// Responder end of the register-block memory interface; drives a single-port SRAM.
// Acks, errors and read data are one-cycle registered pulses (safe for pulse CDC).
//   mem_clk, mem_rst_n : clock, async active-low reset
//   soft_rst           : synchronous clear, active-high
//   bus                : request/ack bus (slave modport)
//   sram_*             : SRAM macro control, address, write data, read data
module reg_mem_responder
  import reg_mem_pkg::*;
#(
  parameter int unsigned MEM_DATA_WIDTH  = 64,
  parameter int unsigned MEM_ADDR_WIDTH  = 5,
  parameter int unsigned MEM_DEPTH       = 32,
  parameter int unsigned SRAM_RD_LATENCY = 1
) (
  input  logic                      mem_clk,
  input  logic                      mem_rst_n,
  input  logic                      soft_rst,
  reg_mem_responder_if.slave        bus,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEM_DATA_WIDTH-1:0] sram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] sram_rdata
);

  localparam int unsigned CNT_W  = $clog2(SRAM_RD_LATENCY + 1);
  localparam int unsigned ADDR_X = MEM_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SRAM_RD_LATENCY - 1);
  localparam logic [ADDR_X-1:0] DEPTH_EXT = ADDR_X'(MEM_DEPTH);

  // Elaboration-time parameter range checks
  if (SRAM_RD_LATENCY < 1 || SRAM_RD_LATENCY > SRAM_RD_LATENCY_MAX) begin : g_bad_latency
    $error("reg_mem_responder: SRAM_RD_LATENCY out of range 1..4");
  end
  if (MEM_DEPTH > (32'd1 << MEM_ADDR_WIDTH)) begin : g_bad_depth
    $error("reg_mem_responder: MEM_DEPTH exceeds address space");
  end

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                wr_q;
  logic                illegal_c;
  logic                ld_c;
  logic                ce_nx, we_nx, ack_nx, err_nx;
  logic [MEM_DATA_WIDTH-1:0] rd_nx;

  // Bad command (both/neither) or address beyond implemented depth
  assign illegal_c = (bus.mem_wr_en == bus.mem_rd_en) ||
                     ({1'b0, bus.mem_addr} >= DEPTH_EXT);

  // Next state and next registered-output values
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ld_c     = 1'b0;
    ce_nx    = 1'b0;
    we_nx    = 1'b0;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    rd_nx    = '0;
    case (state)
      IDLE: begin
        if (bus.mem_req_vld) begin
          if (illegal_c) begin
            state_nx = ACK;
            ack_nx   = 1'b1;
            err_nx   = 1'b1;
          end else begin
            state_nx = ACCESS;
            ld_c     = 1'b1;
            ce_nx    = 1'b1;
            we_nx    = bus.mem_wr_en;
          end
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_nx = ACK;
          ack_nx   = 1'b1;
        end else begin
          state_nx = RDWAIT;
          cnt_nx   = CNT_LOAD;
        end
      end
      RDWAIT: begin
        // Counter reaches zero in the cycle sram_rdata becomes valid
        if (cnt == '0) begin
          state_nx = ACK;
          ack_nx   = 1'b1;
          rd_nx    = sram_rdata;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ACK: begin
        state_nx = RECOVER;
      end
      RECOVER: begin
        // Hold off re-acceptance until the initiator drops its request level
        if (!bus.mem_req_vld) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counter, latched request and output registers
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      wr_q            <= 1'b0;
      sram_ce         <= 1'b0;
      sram_we         <= 1'b0;
      sram_addr       <= '0;
      sram_wdata      <= '0;
      bus.mem_ack_vld <= 1'b0;
      bus.mem_err     <= 1'b0;
      bus.mem_rd_data <= '0;
    end else if (soft_rst) begin
      state           <= IDLE;
      cnt             <= '0;
      wr_q            <= 1'b0;
      sram_ce         <= 1'b0;
      sram_we         <= 1'b0;
      sram_addr       <= '0;
      sram_wdata      <= '0;
      bus.mem_ack_vld <= 1'b0;
      bus.mem_err     <= 1'b0;
      bus.mem_rd_data <= '0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      sram_ce         <= ce_nx;
      sram_we         <= we_nx;
      bus.mem_ack_vld <= ack_nx;
      bus.mem_err     <= err_nx;
      bus.mem_rd_data <= rd_nx;
      if (ld_c) begin
        wr_q       <= bus.mem_wr_en;
        sram_addr  <= bus.mem_addr;
        sram_wdata <= bus.mem_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_mem_responder.sv
// Bench for reg_mem_responder: four instances (read latency 1..4, depth 20),
// each with a behavioural SRAM, checked every cycle against a cycle-indexed
// expectation table built from the protocol's latency/error rules.
module tb_reg_mem_responder;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 20;
  localparam int          NI    = 4;

  typedef struct packed {
    logic          ack;
    logic          err;
    logic [DW-1:0] rd;
    logic          ce;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rst;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance stimulus
  logic          rst_n [NI];
  logic          sr    [NI];
  logic          req   [NI];
  logic          wr    [NI];
  logic          rd    [NI];
  logic [AW-1:0] addr  [NI];
  logic [DW-1:0] wdata [NI];

  // Per-instance observed outputs
  wire          ack_o [NI];
  wire          err_o [NI];
  wire [DW-1:0] rdd_o [NI];
  wire          ce_o  [NI];
  wire          we_o  [NI];
  wire [AW-1:0] sa_o  [NI];
  wire [DW-1:0] swd_o [NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned L = g + 1;
    reg_mem_responder_if #(.MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) bus ();
    wire          ce_w, we_w;
    wire [AW-1:0] sa_w;
    wire [DW-1:0] swd_w;
    logic [DW-1:0] smem [32];
    logic [DW-1:0] pipe [L];

    assign bus.mem_req_vld = req[g];
    assign bus.mem_wr_en   = wr[g];
    assign bus.mem_rd_en   = rd[g];
    assign bus.mem_addr    = addr[g];
    assign bus.mem_wr_data = wdata[g];
    assign ack_o[g] = bus.mem_ack_vld;
    assign err_o[g] = bus.mem_err;
    assign rdd_o[g] = bus.mem_rd_data;
    assign ce_o[g]  = ce_w;
    assign we_o[g]  = we_w;
    assign sa_o[g]  = sa_w;
    assign swd_o[g] = swd_w;

    reg_mem_responder #(
      .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW),
      .MEM_DEPTH(DEPTH), .SRAM_RD_LATENCY(L)
    ) dut (
      .mem_clk(clk), .mem_rst_n(rst_n[g]), .soft_rst(sr[g]), .bus(bus),
      .sram_ce(ce_w), .sram_we(we_w), .sram_addr(sa_w), .sram_wdata(swd_w),
      .sram_rdata(pipe[L-1])
    );

    // Behavioural SRAM: data valid exactly L cycles after the read cycle, garbage otherwise
    initial for (int k = 0; k < 32; k++) smem[k] = '0;
    always @(posedge clk) begin
      if (ce_w && we_w) smem[sa_w] <= swd_w;
      pipe[0] <= (ce_w && !we_w) ? smem[sa_w] : {$urandom, $urandom};
      for (int k = 1; k < int'(L); k++) pipe[k] <= pipe[k-1];
    end
  end

  // Reference model state
  exp_t          exp_tab [int];
  logic [DW-1:0] model_mem [NI][32];
  logic [AW-1:0] m_addr  [NI];
  logic [DW-1:0] m_wdata [NI];
  int            nf      [NI];
  int            ack_cnt [NI];
  int            ack_cyc [NI];
  logic [DW-1:0] ack_rd  [NI];
  logic          ack_err [NI];
  bit            chk_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  function automatic int key(input int c, input int i);
    return c * NI + i;
  endfunction

  // Compare process: every cycle, every instance
  always @(negedge clk) begin
    exp_t e;
    logic [136:0] got, want;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        e = exp_tab.exists(key(cyc, i)) ? exp_tab[key(cyc, i)] : '0;
        if (e.rst) begin
          m_addr[i]  = '0;
          m_wdata[i] = '0;
        end
        if (e.ce) begin
          m_addr[i]  = e.addr;
          m_wdata[i] = e.wdata;
        end
        got  = {ack_o[i], err_o[i], rdd_o[i], ce_o[i], we_o[i], sa_o[i], swd_o[i]};
        want = {e.ack, e.err, e.rd, e.ce, e.we, m_addr[i], m_wdata[i]};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL cycle inst%0d cyc%0d: got ack=%b err=%b rd=%h ce=%b we=%b addr=%0d wd=%h, required ack=%b err=%b rd=%h ce=%b we=%b addr=%0d wd=%h",
                   i, cyc, ack_o[i], err_o[i], rdd_o[i], ce_o[i], we_o[i], sa_o[i], swd_o[i],
                   e.ack, e.err, e.rd, e.ce, e.we, m_addr[i], m_wdata[i]);
        end
        if (ack_o[i] === 1'b1) begin
          ack_cnt[i]++;
          ack_cyc[i] = cyc;
          ack_rd[i]  = rdd_o[i];
          ack_err[i] = err_o[i];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Schedule the expected SRAM cycle and ack of a request whose cycle 0 is c0
  function automatic int sched(input int i, input int c0, input bit w, input bit r,
                               input int a, input logic [DW-1:0] d);
    exp_t e;
    bit   ill;
    int   lat;
    ill = (w == r) || (a >= int'(DEPTH));
    lat = ill ? 1 : (w ? 2 : 2 + (i + 1));
    if (!ill) begin
      e = '0; e.ce = 1'b1; e.we = w; e.addr = AW'(a); e.wdata = d;
      exp_tab[key(c0 + 1, i)] = e;
    end
    e = '0; e.ack = 1'b1; e.err = ill;
    if (!ill && r) e.rd = model_mem[i][a];
    exp_tab[key(c0 + lat, i)] = e;
    if (!ill && w) model_mem[i][a] = d;
    return lat;
  endfunction

  task automatic drop(input int i);
    req[i]   = 1'b0;
    wr[i]    = 1'($urandom);
    rd[i]    = 1'($urandom);
    addr[i]  = AW'($urandom);
    wdata[i] = {$urandom, $urandom};
  endtask

  // One request: raise in an idle cycle, hold 'hold' cycles past ack, drop
  task automatic txn(input int i, input bit w, input bit r, input int a,
                     input logic [DW-1:0] d, input int hold, output int c0);
    int lat;
    wait_to(nf[i]);
    c0 = cyc;
    req[i] = 1'b1; wr[i] = w; rd[i] = r; addr[i] = AW'(a); wdata[i] = d;
    lat = sched(i, c0, w, r, a, d);
    wait_to(c0 + lat + hold);
    drop(i);
    nf[i] = ((hold > 0) ? (c0 + lat + hold) : (c0 + lat + 1)) + 1;
    wait_to(nf[i]);
  endtask

  // Read at addr 0 interrupted in RDWAIT by soft or async reset; request stays high
  task automatic rst_mid(input int i, input bit async_rst, input string name);
    int c0, c1, lat, n;
    exp_t e;
    logic [DW-1:0] d;
    wait_to(nf[i]);
    n  = ack_cnt[i];
    c0 = cyc;
    d  = {$urandom, $urandom};
    req[i] = 1'b1; wr[i] = 1'b0; rd[i] = 1'b1; addr[i] = '0; wdata[i] = d;
    lat = sched(i, c0, 1'b0, 1'b1, 0, d);
    wait_to(c0 + 3);
    exp_tab.delete(key(c0 + lat, i));
    e = '0; e.rst = 1'b1;
    exp_tab[key(c0 + 4, i)] = e;
    if (async_rst) begin #1; rst_n[i] = 1'b0; end
    else sr[i] = 1'b1;
    @(negedge clk);
    if (async_rst) begin #1; rst_n[i] = 1'b1; end
    else sr[i] = 1'b0;
    c1  = c0 + 4;
    lat = sched(i, c1, 1'b0, 1'b1, 0, d);
    wait_to(c1 + lat);
    drop(i);
    nf[i] = c1 + lat + 2;
    wait_to(nf[i]);
    chk({name, "_acks"}, DW'(ack_cnt[i] - n), 64'd1);
    chk({name, "_lat"}, DW'(ack_cyc[i] - c1), 64'd6);
    chk({name, "_data"}, ack_rd[i], 64'hA5A5_0000_0000_0003);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, n, ii, sel, hold;
    bit w, r;
    logic [DW-1:0] d;
    int rd_lat [NI];
    rd_lat = '{3, 4, 5, 6};
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; sr[i] = 1'b0; req[i] = 1'b0; wr[i] = 1'b0; rd[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; m_addr[i] = '0; m_wdata[i] = '0;
      ack_cnt[i] = 0; ack_cyc[i] = 0; ack_rd[i] = '0; ack_err[i] = 1'b0;
      for (int k = 0; k < 32; k++) model_mem[i][k] = '0;
    end
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b1;
      nf[i] = cyc + 1;
    end
    @(negedge clk);

    // Write then read, latency 1
    txn(0, 1'b1, 1'b0, 5, 64'hDEAD_BEEF_0123_4567, 0, c0);
    chk("wr_lat", DW'(ack_cyc[0] - c0), 64'd2);
    chk("wr_err", DW'(ack_err[0]), 64'd0);
    txn(0, 1'b0, 1'b1, 5, 64'h0, 0, c0);
    chk("rd_lat", DW'(ack_cyc[0] - c0), 64'd3);
    chk("rd_data", ack_rd[0], 64'hDEAD_BEEF_0123_4567);

    // Out of range and bad commands
    txn(0, 1'b0, 1'b1, 25, 64'h0, 0, c0);
    chk("oor_lat", DW'(ack_cyc[0] - c0), 64'd1);
    chk("oor_err", DW'(ack_err[0]), 64'd1);
    chk("oor_rd", ack_rd[0], 64'd0);
    txn(0, 1'b1, 1'b1, 3, 64'h1234, 0, c0);
    chk("both_lat", DW'(ack_cyc[0] - c0), 64'd1);
    chk("both_err", DW'(ack_err[0]), 64'd1);
    txn(0, 1'b0, 1'b0, 3, 64'h1234, 0, c0);
    chk("none_lat", DW'(ack_cyc[0] - c0), 64'd1);
    chk("none_err", DW'(ack_err[0]), 64'd1);

    // Read latency sweep
    for (int i = 0; i < NI; i++) begin
      txn(i, 1'b1, 1'b0, 0, 64'hA5A5_0000_0000_0000 | DW'(i), 0, c0);
      txn(i, 1'b0, 1'b1, 0, 64'h0, 0, c0);
      chk($sformatf("sweep_lat_%0d", i), DW'(ack_cyc[i] - c0), DW'(rd_lat[i]));
      chk($sformatf("sweep_data_%0d", i), ack_rd[i], 64'hA5A5_0000_0000_0000 | DW'(i));
    end

    // Held request: one ack, then one-cycle drop and a second request
    n = ack_cnt[1];
    txn(1, 1'b1, 1'b0, 7, 64'h0BAD_CAFE_0000_0007, 6, c0);
    chk("held_acks", DW'(ack_cnt[1] - n), 64'd1);
    txn(1, 1'b0, 1'b1, 7, 64'h0, 0, c0);
    chk("held_second_acks", DW'(ack_cnt[1] - n), 64'd2);
    chk("held_second_data", ack_rd[1], 64'h0BAD_CAFE_0000_0007);

    // Reset in the middle of a latency-4 read
    rst_mid(3, 1'b0, "softrst");
    rst_mid(3, 1'b1, "asyncrst");

    // Randomized traffic
    repeat (200) begin
      ii  = $urandom_range(0, NI - 1);
      sel = $urandom_range(0, 9);
      w   = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : 1'($urandom);
      r   = (sel <= 1) ? w : !w;
      d   = {$urandom, $urandom};
      hold = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn(ii, w, r, $urandom_range(0, 31), d, hold, c0);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
